// File: rtl/ir_err_gen.sv
// ir_err_gen: periodic IR line-sensor scan sequencer. Enables the emitters, lets them settle,
// converts the eight sensor channels through the shared A2D handshake and publishes a
// saturated, weighted right-minus-left error plus a line-present flag with a one-cycle strobe.
module ir_err_gen #(
    parameter int unsigned PERIOD_CYC = 65536,
    parameter int unsigned SETTLE_CYC = 4096,
    parameter int unsigned LINE_THRES = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        IR_en,
    output logic [15:0] error,
    output logic        err_vld,
    output logic        line_present
);

    // One counter serves both the IDLE period and the SETTLE time
    localparam int unsigned MaxCyc = (PERIOD_CYC > SETTLE_CYC) ? PERIOD_CYC : SETTLE_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc);

    localparam logic [CntW-1:0] PeriodLast = CntW'(PERIOD_CYC - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCnv,
        StWait,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic signed [16:0] err_acc_q, err_acc_d;
    logic [14:0]        int_acc_q, int_acc_d;
    logic [15:0]        error_q, error_d;
    logic               line_q, line_d;
    logic               err_vld_q, err_vld_d;

    logic [14:0]        w_res;
    logic [15:0]        err_sat;

    // State register and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            err_acc_q <= '0;
            int_acc_q <= '0;
            error_q   <= '0;
            line_q    <= 1'b0;
            err_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            err_acc_q <= err_acc_d;
            int_acc_q <= int_acc_d;
            error_q   <= error_d;
            line_q    <= line_d;
            err_vld_q <= err_vld_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cnt_q == PeriodLast && en) state_d = StSettle;
            StSettle: if (cnt_q == SettleLast) state_d = StCnv;
            StCnv:    state_d = StWait;
            StWait:   if (cnv_cmplt) state_d = (idx_q == 3'd7) ? StDone : StCnv;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Weighted sample (1,2,4,8 by position within a side) and saturation of the accumulator
    always_comb begin
        w_res = {3'b000, res} << idx_q[1:0];
        // Value fits in 16-bit signed exactly when the top two accumulator bits agree
        if (err_acc_q[16] != err_acc_q[15]) begin
            err_sat = err_acc_q[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            err_sat = err_acc_q[15:0];
        end
    end

    // Counter, channel index, accumulators and published results
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        err_acc_d = err_acc_q;
        int_acc_d = int_acc_q;
        error_d   = error_q;
        line_d    = line_q;
        err_vld_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cnt_q != PeriodLast) begin
                    cnt_d = cnt_q + CntW'(1);
                end else if (en) begin
                    // Count holds at the last value while en is low
                    cnt_d     = '0;
                    idx_d     = '0;
                    err_acc_d = '0;
                    int_acc_d = '0;
                end
            end
            StSettle: begin
                cnt_d = (cnt_q == SettleLast) ? '0 : cnt_q + CntW'(1);
            end
            StWait: begin
                if (cnv_cmplt) begin
                    // Channels 4..7 are on the right and add; 0..3 are on the left and subtract
                    if (idx_q[2]) begin
                        err_acc_d = err_acc_q + $signed({2'b00, w_res});
                    end else begin
                        err_acc_d = err_acc_q - $signed({2'b00, w_res});
                    end
                    int_acc_d = int_acc_q + {3'b000, res};
                    if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
                end
            end
            StDone: begin
                error_d   = err_sat;
                line_d    = ({17'd0, int_acc_q} > LINE_THRES);
                err_vld_d = 1'b1;
                cnt_d     = '0;
                idx_d     = '0;
            end
            default: ;
        endcase
    end

    // Moore outputs decoded from state plus registered results
    always_comb begin
        strt_cnv     = (state_q == StCnv);
        IR_en        = (state_q == StSettle) || (state_q == StCnv) || (state_q == StWait);
        chnnl        = idx_q;
        error        = error_q;
        err_vld      = err_vld_q;
        line_present = line_q;
    end

endmodule

// File: tb/tb_ir_err_gen.sv
// tb_ir_err_gen: directed and randomized scans of ir_err_gen against an arithmetic model.
module tb_ir_err_gen;

    localparam int unsigned P  = 16;
    localparam int unsigned S  = 4;
    localparam int unsigned TH = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        IR_en;
    logic [15:0] error;
    logic        err_vld;
    logic        line_present;

    ir_err_gen #(
        .PERIOD_CYC (P),
        .SETTLE_CYC (S),
        .LINE_THRES (TH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .strt_cnv     (strt_cnv),
        .chnnl        (chnnl),
        .cnv_cmplt    (cnv_cmplt),
        .res          (res),
        .IR_en        (IR_en),
        .error        (error),
        .err_vld      (err_vld),
        .line_present (line_present)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int ir_hi = 0;
    int st_n  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (IR_en === 1'b1) ir_hi <= ir_hi + 1;
        if (strt_cnv === 1'b1) st_n <= st_n + 1;
    end

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          rv[8];
    logic [15:0] exp_err  = 16'h0000;
    logic        exp_line = 1'b0;
    int          last_vld = 0;
    int          rst_cyc  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed weighted right-minus-left sum, saturated; raw sum against threshold
    task automatic model(output logic [15:0] e, output logic l);
        int s = 0;
        int t = 0;
        for (int c = 0; c < 8; c++) begin
            t += rv[c];
            if (c >= 4) s += rv[c] * (1 << (c % 4));
            else        s -= rv[c] * (1 << (c % 4));
        end
        if (s > 32767)       e = 16'h7FFF;
        else if (s < -32768) e = 16'h8000;
        else                 e = 16'(s);
        l = (t > int'(TH));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strt"}, strt_cnv, 0);
        check({tag, "_chnnl"}, chnnl, 0);
        check({tag, "_iren"}, IR_en, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_vld"}, err_vld, 0);
        check({tag, "_line"}, line_present, 0);
    endtask

    // Acts as the A2D for one scan. rst_ch < 8 resets in that channel's WAIT; drop_ch < 8
    // lowers en at that channel's conversion start.
    task automatic run_scan(input int lat, input bit spurious, input int rst_ch,
                            input int drop_ch, input bit chk_ir);
        int n = 0;
        int ir0 = ir_hi;
        int st0 = st_n;
        logic [15:0] e_new;
        logic        l_new;
        while (strt_cnv !== 1'b1 && n < 400) begin
            if (spurious && $urandom_range(0, 3) == 0) begin
                cnv_cmplt = 1'b1;
                res       = 12'($urandom_range(0, 4095));
            end else begin
                cnv_cmplt = 1'b0;
            end
            step();
            n++;
        end
        cnv_cmplt = 1'b0;
        check("scan_start", strt_cnv, 1);
        if (strt_cnv !== 1'b1) return;
        for (int i = 0; i < 8; i++) begin
            check("strt_cnv", strt_cnv, 1);
            check("chnnl_cnv", chnnl, i);
            check("iren_cnv", IR_en, 1);
            if (i == drop_ch) en = 1'b0;
            for (int k = 1; k <= lat; k++) begin
                step();
                if (k == 1) check("strt_wait", strt_cnv, 0);
                if (i == rst_ch && k == 1) begin
                    rst_n = 1'b0;
                    step();
                    rst_n   = 1'b1;
                    rst_cyc = cyc;
                    check_reset_outputs("midrst");
                    cnv_cmplt = 1'b1;
                    res       = 12'd4095;
                    step();
                    cnv_cmplt = 1'b0;
                    check("midrst_late_iren", IR_en, 0);
                    check("midrst_late_strt", strt_cnv, 0);
                    check("midrst_late_error", error, 0);
                    exp_err  = 16'h0000;
                    exp_line = 1'b0;
                    return;
                end
                if (k == lat) begin
                    cnv_cmplt = 1'b1;
                    res       = 12'(rv[i]);
                end
            end
            check("chnnl_cmplt", chnnl, i);
            step();
            cnv_cmplt = 1'b0;
            res       = 12'($urandom_range(0, 4095));
        end
        // DONE cycle: emitters off, results not yet published
        check("done_iren", IR_en, 0);
        check("done_vld", err_vld, 0);
        check("done_error_held", error, exp_err);
        step();
        model(e_new, l_new);
        exp_err  = e_new;
        exp_line = l_new;
        last_vld = cyc;
        check("err_vld", err_vld, 1);
        check("error", error, exp_err);
        check("line_present", line_present, exp_line);
        step();
        check("err_vld_drop", err_vld, 0);
        check("error_hold", error, exp_err);
        check("strt_count", st_n - st0, 8);
        if (chk_ir) check("iren_cycles", ir_hi - ir0, S + 8 * (1 + lat));
    endtask

    int v1;
    int lat_r;
    int ir_s;
    int st_s;

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        cnv_cmplt = 1'b0;
        res       = '0;
        step();
        step();
        step();
        check_reset_outputs("reset");
        rst_cyc = cyc;
        rst_n   = 1'b1;

        // All channels 100, L=3: balanced error, weak intensity
        for (int c = 0; c < 8; c++) rv[c] = 100;
        run_scan(3, 0, 8, 8, 1);
        check("first_vld_latency", last_vld - rst_cyc, P + S + 8 * 4 + 1);

        // Outermost right at full scale
        for (int c = 0; c < 8; c++) rv[c] = (c == 7) ? 4095 : 0;
        run_scan(2, 1, 8, 8, 1);
        check("ch7_error_const", error, 16'h7FF8);

        // Left full scale saturates negative, right full scale saturates positive
        for (int c = 0; c < 8; c++) rv[c] = (c < 4) ? 4095 : 0;
        run_scan(1, 1, 8, 8, 1);
        check("left_sat_const", error, 16'h8000);
        for (int c = 0; c < 8; c++) rv[c] = (c < 4) ? 0 : 4095;
        run_scan(4, 1, 8, 8, 1);
        check("right_sat_const", error, 16'h7FFF);

        // Back-to-back scans with L=5 and spurious completions in IDLE/SETTLE
        for (int c = 0; c < 8; c++) rv[c] = $urandom_range(0, 4095);
        run_scan(5, 1, 8, 8, 1);
        v1 = last_vld;
        for (int c = 0; c < 8; c++) rv[c] = $urandom_range(0, 4095);
        run_scan(5, 1, 8, 8, 1);
        check("vld_spacing", last_vld - v1, 69);

        // Randomized scans, mixing strong and weak intensities
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                rv[c] = $urandom_range(0, ($urandom_range(0, 1) == 1) ? 4095 : 500);
            end
            lat_r = $urandom_range(1, 4);
            run_scan(lat_r, 1, 8, 8, 1);
        end

        // Reset in the WAIT of channel 3, then a clean scan from channel 0
        for (int c = 0; c < 8; c++) rv[c] = $urandom_range(0, 4095);
        run_scan(2, 0, 3, 8, 0);
        for (int c = 0; c < 8; c++) rv[c] = $urandom_range(0, 4095);
        run_scan(5, 0, 8, 8, 1);
        check("post_reset_latency", last_vld - rst_cyc, 69);

        // en low at end of IDLE: nothing starts and results hold
        en   = 1'b0;
        ir_s = ir_hi;
        st_s = st_n;
        for (int k = 0; k < 40; k++) step();
        check("en0_iren", IR_en, 0);
        check("en0_iren_cycles", ir_hi - ir_s, 0);
        check("en0_strt_count", st_n - st_s, 0);
        check("en0_error_hold", error, exp_err);
        check("en0_line_hold", line_present, exp_line);
        en = 1'b1;
        step();
        check("en_rise_iren", IR_en, 1);
        for (int c = 0; c < 8; c++) rv[c] = $urandom_range(0, 4095);
        run_scan(3, 0, 8, 2, 0);
        en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
